// File: rtl/usb_phy_pkg.sv
// Shared USB PHY definitions: symbol width, serializer state encodings and
// the K28.5 (RD-) comma symbol.
package usb_phy_pkg;

    localparam int SYM_W = 10;

    localparam logic [SYM_W-1:0] K28_5_RDN = 10'h0FA;

    // Bit index of the last bit of a symbol; the fetch slot sits here.
    localparam logic [3:0] CNT_LAST = 4'd9;

    typedef enum logic [1:0] {
        TX_OFF   = 2'd0,
        TX_RUN   = 2'd1,
        TX_DRAIN = 2'd2
    } tx_state_e;

endpackage

// File: rtl/usb_ser_shifter.sv
// LSB-first 10-bit symbol shifter with bit counter; load takes priority over
// shift and restarts the count at bit 0.
module usb_ser_shifter
    import usb_phy_pkg::*;
(
    input  logic             Serialclk,
    input  logic             SerialRST,
    input  logic             load,
    input  logic             shift,
    input  logic [SYM_W-1:0] load_sym,
    output logic             bit0,
    output logic [3:0]       cnt
);

    logic [SYM_W-1:0] sr_q;
    logic [3:0]       cnt_q;

    always_ff @(posedge Serialclk or negedge SerialRST) begin
        if (!SerialRST) begin
            sr_q  <= '0;
            cnt_q <= 4'd0;
        end else if (load) begin
            sr_q  <= load_sym;
            cnt_q <= 4'd0;
        end else if (shift) begin
            // Zero fill keeps the register empty once the last bit leaves.
            sr_q  <= {1'b0, sr_q[SYM_W-1:1]};
            cnt_q <= (cnt_q == CNT_LAST) ? 4'd0 : cnt_q + 4'd1;
        end
    end

    assign bit0 = sr_q[0];
    assign cnt  = cnt_q;

endmodule

// File: rtl/usb_ser_tx_ctrl.sv
// Serializer controller: Train-over-Data arbitration at symbol boundaries,
// OFF/RUN/DRAIN sequencing and underrun accounting. Build option
// USB_SER_IDLE_FILL_EN selects IDLE_SYM instead of zeros as underrun fill.
module usb_ser_tx_ctrl
    import usb_phy_pkg::*;
#(
    parameter logic [SYM_W-1:0] IDLE_SYM = K28_5_RDN
) (
    input  logic             Serialclk,
    input  logic             SerialRST,
    input  logic             TxEn,
    input  logic [SYM_W-1:0] TrainIn,
    input  logic             TrainValid,
    output logic             TrainReady,
    input  logic [SYM_W-1:0] DataIn,
    input  logic             DataValid,
    output logic             DataReady,
    output logic             SerialOut,
    output logic             SymStrobe,
    output logic [1:0]       TxState,
    output logic [7:0]       UnderrunCnt
);

`ifdef USB_SER_IDLE_FILL_EN
    localparam logic [SYM_W-1:0] FILL_SYM = IDLE_SYM;
`else
    localparam logic [SYM_W-1:0] FILL_SYM = '0;
`endif

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    tx_state_e        state_q, state_d;
    logic             fetch_raw, fetch_slot, shift_en, underrun;
    logic             last_bit, bit0;
    logic [3:0]       cnt;
    logic [SYM_W-1:0] load_sym;
    logic             strobe_q;
    logic [7:0]       urun_q;

    assign last_bit = (cnt == CNT_LAST);

    always_ff @(posedge Serialclk or negedge SerialRST) begin
        if (!SerialRST) state_q <= TX_OFF;
        else            state_q <= state_d;
    end

    // A fetch only ever happens on a symbol boundary, and only with TxEn
    // held; otherwise the symbol in flight keeps shifting to completion.
    always_comb begin
        state_d   = state_q;
        fetch_raw = 1'b0;
        shift_en  = 1'b0;
        case (state_q)
            TX_OFF: begin
                if (TxEn) begin
                    fetch_raw = 1'b1;
                    state_d   = TX_RUN;
                end
            end
            TX_RUN: begin
                if (last_bit && TxEn) begin
                    fetch_raw = 1'b1;
                end else begin
                    shift_en = 1'b1;
                    if (!TxEn) state_d = last_bit ? TX_OFF : TX_DRAIN;
                end
            end
            TX_DRAIN: begin
                if (last_bit && TxEn) begin
                    fetch_raw = 1'b1;
                    state_d   = TX_RUN;
                end else begin
                    shift_en = 1'b1;
                    if (last_bit) state_d = TX_OFF;
                end
            end
            default: state_d = TX_OFF;
        endcase
    end

    // Readies must read 0 while reset is held, even with TxEn high.
    assign fetch_slot = fetch_raw & SerialRST;
    assign underrun   = fetch_slot & ~TrainValid & ~DataValid;

    always_comb begin
        load_sym = FILL_SYM;
        if (TrainValid)     load_sym = TrainIn;
        else if (DataValid) load_sym = DataIn;
    end

    usb_ser_shifter u_shifter (
        .Serialclk (Serialclk),
        .SerialRST (SerialRST),
        .load      (fetch_slot),
        .shift     (shift_en),
        .load_sym  (load_sym),
        .bit0      (bit0),
        .cnt       (cnt)
    );

    always_ff @(posedge Serialclk or negedge SerialRST) begin
        if (!SerialRST) begin
            strobe_q <= 1'b0;
            urun_q   <= 8'd0;
        end else begin
            strobe_q <= fetch_slot;
            if (underrun) urun_q <= sat_inc8(urun_q);
        end
    end

    assign TrainReady  = fetch_slot;
    assign DataReady   = fetch_slot & ~TrainValid;
    assign SerialOut   = (state_q != TX_OFF) & bit0;
    assign SymStrobe   = strobe_q;
    assign TxState     = state_q;
    assign UnderrunCnt = urun_q;

endmodule

// File: tb/tb_usb_ser_tx_ctrl.sv
// Scoreboard bench for usb_ser_tx_ctrl: stimulus queues expected bit/strobe
// pairs, a negedge monitor pops one per serializing cycle.
module tb_usb_ser_tx_ctrl;

`ifdef USB_SER_IDLE_FILL_EN
    localparam logic [9:0] FILL = 10'h0FA;
`else
    localparam logic [9:0] FILL = 10'h000;
`endif

    logic       clk = 1'b0;
    logic       SerialRST;
    logic       TxEn;
    logic [9:0] TrainIn;
    logic       TrainValid;
    logic       TrainReady;
    logic [9:0] DataIn;
    logic       DataValid;
    logic       DataReady;
    logic       SerialOut;
    logic       SymStrobe;
    logic [1:0] TxState;
    logic [7:0] UnderrunCnt;

    typedef struct packed {
        logic b;
        logic s;
    } exp_t;

    exp_t sb_q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    usb_ser_tx_ctrl dut (
        .Serialclk   (clk),
        .SerialRST   (SerialRST),
        .TxEn        (TxEn),
        .TrainIn     (TrainIn),
        .TrainValid  (TrainValid),
        .TrainReady  (TrainReady),
        .DataIn      (DataIn),
        .DataValid   (DataValid),
        .DataReady   (DataReady),
        .SerialOut   (SerialOut),
        .SymStrobe   (SymStrobe),
        .TxState     (TxState),
        .UnderrunCnt (UnderrunCnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_sym(input logic [9:0] sym);
        for (int i = 0; i < 10; i++) begin
            exp_t x;
            x.b = sym[i];
            x.s = (i == 0);
            sb_q.push_back(x);
        end
    endtask

    // Wait for the fetch slot, which must come on the exp_n-th negedge.
    task automatic fetch(input logic [9:0] sym, input logic exp_dr, input int exp_n);
        int n;
        bit seen;
        n = 0;
        seen = 0;
        while (!seen && n < exp_n + 2) begin
            @(negedge clk);
            n++;
            if (TrainReady === 1'b1) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL fetch_timeout: no TrainReady within %0d cycles, expected on cycle %0d", n, exp_n);
        end else begin
            chk("slot_pos", n, exp_n);
            chk("data_ready", DataReady, exp_dr);
            push_sym(sym);
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (SerialRST === 1'b1) begin
            if (TxState != 2'd0) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_empty: serial bit %0b with no expected entry at %0t", SerialOut, $time);
                end else begin
                    e = sb_q.pop_front();
                    chk("serial_bit", SerialOut, e.b);
                    chk("sym_strobe", SymStrobe, e.s);
                end
            end else begin
                chk("off_out", SerialOut, 0);
                chk("off_strobe", SymStrobe, 0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        SerialRST  = 1'b0;
        TxEn       = 1'b1;
        TrainIn    = 10'h000;
        TrainValid = 1'b0;
        DataIn     = 10'h155;
        DataValid  = 1'b1;

        // Reset state, with TxEn already high
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_serial", SerialOut, 0);
        chk("rst_strobe", SymStrobe, 0);
        chk("rst_state", TxState, 0);
        chk("rst_urun", UnderrunCnt, 0);
        chk("rst_train_rdy", TrainReady, 0);
        chk("rst_data_rdy", DataReady, 0);
        @(posedge clk);
        #1;
        SerialRST = 1'b1;

        // 0x155 sent right after release
        fetch(10'h155, 1'b1, 1);

        // Train wins over Data
        TrainValid = 1'b1;
        TrainIn    = 10'h3FF;
        DataIn     = 10'h000;
        fetch(10'h3FF, 1'b0, 10);
        TrainValid = 1'b0;
        fetch(10'h000, 1'b1, 10);

        // Three underruns
        DataValid = 1'b0;
        repeat (3) fetch(FILL, 1'b1, 10);
        chk("urun_three", UnderrunCnt, 3);

        // Drop TxEn at cnt==4 and drain
        DataValid = 1'b1;
        DataIn    = 10'h0F0;
        fetch(10'h0F0, 1'b1, 10);
        repeat (4) @(posedge clk);
        #1;
        TxEn = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("drain_state", TxState, 2);
            chk("drain_train_rdy", TrainReady, 0);
            chk("drain_data_rdy", DataReady, 0);
        end
        @(negedge clk);
        chk("post_drain_state", TxState, 0);
        chk("post_drain_serial", SerialOut, 0);
        @(posedge clk);
        #1;

        // Reset at cnt==6
        TxEn   = 1'b1;
        DataIn = 10'h3C3;
        fetch(10'h3C3, 1'b1, 1);
        repeat (6) @(posedge clk);
        #2;
        SerialRST = 1'b0;
        sb_q.delete();
        #1;
        chk("mid_rst_serial", SerialOut, 0);
        chk("mid_rst_strobe", SymStrobe, 0);
        chk("mid_rst_state", TxState, 0);
        chk("mid_rst_urun", UnderrunCnt, 0);
        chk("mid_rst_train_rdy", TrainReady, 0);
        chk("mid_rst_data_rdy", DataReady, 0);
        repeat (2) @(posedge clk);
        #1;
        TxEn      = 1'b0;
        SerialRST = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_state", TxState, 0);
        chk("idle_train_rdy", TrainReady, 0);
        @(posedge clk);
        #1;
        TxEn   = 1'b1;
        DataIn = 10'h1E1;
        fetch(10'h1E1, 1'b1, 1);

        // Saturating underrun counter
        DataValid = 1'b0;
        repeat (254) fetch(FILL, 1'b1, 10);
        chk("urun_254", UnderrunCnt, 254);
        repeat (46) fetch(FILL, 1'b1, 10);
        chk("urun_sat", UnderrunCnt, 255);

        TxEn = 1'b0;
        repeat (12) @(negedge clk);
        chk("final_state", TxState, 0);
        chk("sb_drained", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/usb_ser_tx_ctrl.md
USB_SER_TX_CTRL -- requirements
Module: usb_ser_tx_ctrl

Interface
REQ-001 SHALL have parameter IDLE_SYM, default 10'h0FA (K28.5, RD-), the symbol sent on underrun when fill is enabled.
REQ-002 SHALL have these ports, one per line:
- Serialclk  in  1  bit clock; all logic on its rising edge.
- SerialRST  in  1  asynchronous, active-low reset.
- TxEn  in  1  serializer enable.
- TrainIn  in  10  training/ordered-set symbol.
- TrainValid  in  1  TrainIn valid.
- TrainReady  out  1  training symbol accepted this cycle.
- DataIn  in  10  link data symbol.
- DataValid  in  1  DataIn valid.
- DataReady  out  1  data symbol accepted this cycle.
- SerialOut  out  1  serial bit, LSB first.
- SymStrobe  out  1  one-cycle pulse on the first bit of each symbol.
- TxState  out  2  state: 0 OFF, 1 RUN, 2 DRAIN.
- UnderrunCnt  out  8  saturating count of fetch slots with no valid source.
REQ-003 SHALL use one clock, Serialclk; reset SerialRST SHALL be asynchronous and active-low.

Function
REQ-004 SHALL have a 10-bit shift register and a bit counter cnt (0..9). Each RUN/DRAIN cycle: shift right one bit with zero fill, cnt+1, wrapping 9->0.
REQ-005 SerialOut SHALL equal shift-register bit 0 and SHALL be 0 in OFF.
REQ-006 A fetch slot SHALL be either (a) OFF with TxEn=1, or (b) RUN with cnt==9. DRAIN with cnt==9 and TxEn=1 is also a fetch slot and counts as RUN.
REQ-007 TrainReady and DataReady SHALL be combinational and SHALL be asserted only in a fetch slot.
- TrainReady = fetch slot.
- DataReady = fetch slot AND NOT TrainValid (fixed priority: Train > Data).
REQ-008 A transfer SHALL occur when valid AND ready. The accepted symbol SHALL load at the next edge with cnt=0. Its bit 0 SHALL appear on SerialOut for the cycle after the transfer edge, and bit k SHALL appear k cycles later.
REQ-009 SymStrobe SHALL be high exactly in the cycle bit 0 of a newly loaded symbol is on SerialOut.
REQ-010 Symbol boundaries SHALL be gap-free: back-to-back symbols give a continuous bit stream with SymStrobe every 10 cycles.
REQ-011 A fetch slot with neither source valid SHALL increment UnderrunCnt (saturating at 255) and SHALL load the fill symbol (see Configuration). SymStrobe SHALL still pulse.
REQ-012 State transitions:
- OFF->RUN when TxEn=1 (fetch slot).
- RUN->DRAIN when TxEn=0 and cnt!=9.
- RUN->OFF when TxEn=0 and cnt==9; no fetch.
- DRAIN->OFF when cnt==9 and TxEn=0.
- DRAIN->RUN at cnt==9 with TxEn=1, with a fetch in that slot.
- DRAIN SHALL never accept a symbol before cnt==9.
REQ-013 A symbol in flight SHALL always complete all 10 bits unless reset is asserted.

Reset
REQ-014 Asynchronous reset SHALL force:
- shift register=0, cnt=0, TxState=OFF (0);
- SerialOut=0, SymStrobe=0, UnderrunCnt=0;
- TrainReady=0, DataReady=0.
REQ-015 Reset mid-symbol SHALL abandon the symbol. After release, the first fetch SHALL occur in the first cycle with TxEn=1.

Configuration
REQ-016 Macro USB_SER_IDLE_FILL_EN:
- Defined: an underrun slot loads IDLE_SYM.
- Undefined: an underrun slot loads 10'h000 (ten zero bits).
- UnderrunCnt SHALL behave identically in both cases.

Structure
REQ-017 Shared package usb_phy_pkg SHALL hold:
- SYM_W=10;
- TxState encodings OFF/RUN/DRAIN;
- K28_5_RDN=10'h0FA.
REQ-018 The shift register and counter SHALL be a sub-module usb_ser_shifter (load, shift, cnt, bit0 out), instantiated once. Arbitration and the FSM SHALL live in usb_ser_tx_ctrl.

Verification
REQ-019 Reset release, TxEn=1, DataValid=1, DataIn=10'h155:
- SerialOut=1,0,1,0,1,0,1,0,1,0 on 10 consecutive cycles;
- SymStrobe on the first cycle only.
REQ-020 Train and Data both valid at a fetch slot (TrainIn=10'h3FF, DataIn=10'h000):
- TrainReady=1, DataReady=0;
- ten 1s sent, then Data accepted at the next slot.
REQ-021 No valid source for 3 slots:
- UnderrunCnt=3;
- with macro, SerialOut repeats pattern 0,1,0,1,1,1,1,1,0,0 three times;
- without macro, 30 zeros.
REQ-022 TxEn dropped at cnt==4:
- TxState=2 for 5 cycles, symbol completes, then TxState=0 and SerialOut=0;
- no Ready asserted during DRAIN.
REQ-023 SerialRST asserted at cnt==6 mid-symbol: all outputs 0 immediately, then clean restart after release.
REQ-024 300 consecutive underruns: UnderrunCnt saturates at 255.
